// File: rtl/clefia_tap_delay_line_if.sv
// rtl/clefia_tap_delay_line_if.sv - Port bundle for the CLEFIA round-word delay line
interface clefia_tap_delay_line_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 7,
    parameter int NOUT  = 3
);
    localparam int SW = $clog2(DEPTH);

    logic                  en;
    logic                  flush;
    logic [WIDTH-1:0]      chain_data;
    logic                  chain_valid;
    logic [WIDTH-1:0]      ext_data;
    logic                  ext_valid;
    logic                  src_sel;
    logic [SW-1:0]         tap_sel;
    logic                  err_clr;

    logic [NOUT*WIDTH-1:0] taps_flat;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [SW:0]           fill;
    logic                  full;
    logic                  tap_err;

    modport master (
        output en, flush, chain_data, chain_valid, ext_data, ext_valid,
               src_sel, tap_sel, err_clr,
        input  taps_flat, out_data, out_valid, fill, full, tap_err
    );

    modport slave (
        input  en, flush, chain_data, chain_valid, ext_data, ext_valid,
               src_sel, tap_sel, err_clr,
        output taps_flat, out_data, out_valid, fill, full, tap_err
    );
endinterface

// File: rtl/clefia_tap_delay_line.sv
// rtl/clefia_tap_delay_line.sv - Round-word shift chain with selectable tap, output pipe, fill and tap error
module clefia_tap_delay_line #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 7,
    parameter int NOUT    = 3,
    parameter int OUT_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    clefia_tap_delay_line_if.slave bus
);
    localparam int          SW       = $clog2(DEPTH);
    localparam logic [SW:0] FULL_CNT = (SW+1)'(DEPTH);
    localparam logic [SW:0] FILL_ONE = (SW+1)'(1);

    logic [WIDTH-1:0]      chain_q  [DEPTH];
    logic [DEPTH-1:0]      chain_v_q;
    logic [WIDTH-1:0]      pipe_q   [OUT_LAT];
    logic                  pipe_v_q [OUT_LAT];
    logic [SW:0]           fill_q;
    logic [SW:0]           fill_next;
    logic                  tap_err_q;

    logic                  tap_in_range;
    logic                  err_set;
    logic [WIDTH-1:0]      mux_data;
    logic                  mux_valid;
    logic [NOUT*WIDTH-1:0] taps_flat;

    assign tap_in_range = (32'(bus.tap_sel) < 32'(DEPTH));
    assign err_set      = bus.en && bus.src_sel && !tap_in_range && !bus.flush;

    // Out-of-range taps yield an all-zero, invalid word rather than aliasing a stage.
    always_comb begin
        mux_data  = '0;
        mux_valid = 1'b0;
        if (!bus.src_sel) begin
            mux_data  = bus.ext_data;
            mux_valid = bus.ext_valid;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (32'(bus.tap_sel) == 32'(k)) begin
                    mux_data  = chain_q[k];
                    mux_valid = chain_v_q[k];
                end
            end
        end
    end

    // Entry and exit in the same cycle cancel, so the count cannot leave 0..DEPTH.
    always_comb begin
        fill_next = fill_q;
        if (bus.chain_valid && !chain_v_q[DEPTH-1]) begin
            fill_next = fill_q + FILL_ONE;
        end else if (!bus.chain_valid && chain_v_q[DEPTH-1]) begin
            fill_next = fill_q - FILL_ONE;
        end
    end

    // Flush only drops qualifiers; the data words stay in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                chain_q[k] <= '0;
            end
            chain_v_q <= '0;
        end else if (bus.flush) begin
            chain_v_q <= '0;
        end else if (bus.en) begin
            chain_q[0]   <= bus.chain_data;
            chain_v_q[0] <= bus.chain_valid;
            for (int k = 1; k < DEPTH; k++) begin
                chain_q[k]   <= chain_q[k-1];
                chain_v_q[k] <= chain_v_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < OUT_LAT; j++) begin
                pipe_q[j]   <= '0;
                pipe_v_q[j] <= 1'b0;
            end
        end else if (bus.flush) begin
            for (int j = 0; j < OUT_LAT; j++) begin
                pipe_v_q[j] <= 1'b0;
            end
        end else if (bus.en) begin
            pipe_q[0]   <= mux_data;
            pipe_v_q[0] <= mux_valid;
            for (int j = 1; j < OUT_LAT; j++) begin
                pipe_q[j]   <= pipe_q[j-1];
                pipe_v_q[j] <= pipe_v_q[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else if (bus.flush) begin
            fill_q <= '0;
        end else if (bus.en) begin
            fill_q <= fill_next;
        end
    end

    // A new violation in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_err_q <= 1'b0;
        end else if (err_set) begin
            tap_err_q <= 1'b1;
        end else if (bus.err_clr) begin
            tap_err_q <= 1'b0;
        end
    end

    always_comb begin
        taps_flat = '0;
        for (int k = 0; k < NOUT; k++) begin
            taps_flat[k*WIDTH +: WIDTH] = chain_q[k];
        end
    end

    assign bus.taps_flat = taps_flat;
    assign bus.out_data  = pipe_q[OUT_LAT-1];
    assign bus.out_valid = pipe_v_q[OUT_LAT-1];
    assign bus.fill      = fill_q;
    assign bus.full      = (fill_q == FULL_CNT);
    assign bus.tap_err   = tap_err_q;
endmodule

// File: tb/tb_clefia_tap_delay_line.sv
// tb/tb_clefia_tap_delay_line.sv - Randomised bench for clefia_tap_delay_line with queue-based reference
module tb_clefia_tap_delay_line;
    localparam int W  = 32;
    localparam int D  = 7;
    localparam int N  = 3;
    localparam int L  = 2;
    localparam int SW = $clog2(D);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clefia_tap_delay_line_if #(.WIDTH(W), .DEPTH(D), .NOUT(N)) bus ();

    clefia_tap_delay_line #(.WIDTH(W), .DEPTH(D), .NOUT(N), .OUT_LAT(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 0;

    // Reference: newest chain entry / mux result at index 0 of each queue.
    logic [W-1:0] cd_q [$];
    bit           cv_q [$];
    logic [W-1:0] md_q [$];
    bit           mv_q [$];
    bit           m_err;

    function automatic logic [W-1:0] m_stage_d(int k);
        return (k < cd_q.size()) ? cd_q[k] : '0;
    endfunction

    function automatic bit m_stage_v(int k);
        return (k < cv_q.size()) ? cv_q[k] : 1'b0;
    endfunction

    function automatic int m_fill();
        int c = 0;
        foreach (cv_q[i]) c += int'(cv_q[i]);
        return c;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] nd;
        bit           nv;
        bit           eset;
        if (rst) begin
            cd_q.delete(); cv_q.delete(); md_q.delete(); mv_q.delete();
            m_err = 0;
        end else begin
            eset = bus.en && bus.src_sel && (int'(bus.tap_sel) >= D) && !bus.flush;
            if (bus.flush) begin
                foreach (cv_q[i]) cv_q[i] = 0;
                foreach (mv_q[i]) mv_q[i] = 0;
            end else if (bus.en) begin
                if (!bus.src_sel) begin
                    nd = bus.ext_data; nv = bus.ext_valid;
                end else if (int'(bus.tap_sel) < D) begin
                    nd = m_stage_d(int'(bus.tap_sel)); nv = m_stage_v(int'(bus.tap_sel));
                end else begin
                    nd = '0; nv = 0;
                end
                cd_q.push_front(bus.chain_data); cv_q.push_front(bus.chain_valid);
                md_q.push_front(nd); mv_q.push_front(nv);
                while (cd_q.size() > D) begin void'(cd_q.pop_back()); void'(cv_q.pop_back()); end
                while (md_q.size() > L) begin void'(md_q.pop_back()); void'(mv_q.pop_back()); end
            end
            if (eset) m_err = 1;
            else if (bus.err_clr) m_err = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < N; k++) chk($sformatf("model_tap%0d", k), 64'(bus.taps_flat[k*W +: W]), 64'(m_stage_d(k)));
            chk("model_out_data",  64'(bus.out_data),  64'(m_stage_out_d()));
            chk("model_out_valid", 64'(bus.out_valid), 64'(m_stage_out_v()));
            chk("model_fill",      64'(bus.fill),      64'(m_fill()));
            chk("model_full",      64'(bus.full),      64'(m_fill() == D));
            chk("model_tap_err",   64'(bus.tap_err),   64'(m_err));
        end
    end

    function automatic logic [W-1:0] m_stage_out_d();
        return (md_q.size() >= L) ? md_q[L-1] : '0;
    endfunction

    function automatic bit m_stage_out_v();
        return (mv_q.size() >= L) ? mv_q[L-1] : 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; bus.en = 0; bus.flush = 0; bus.chain_data = '0; bus.chain_valid = 0;
        bus.ext_data = '0; bus.ext_valid = 0; bus.src_sel = 0; bus.tap_sel = '0; bus.err_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; tick();
        rst = 0;
    endtask

    initial begin
        // T1: reset under random inputs
        idle();
        rst = 1;
        bus.en = 1; bus.flush = 0; bus.chain_data = $urandom; bus.chain_valid = 1;
        bus.ext_data = $urandom; bus.ext_valid = 1; bus.src_sel = 1'($urandom);
        bus.tap_sel = SW'($urandom); bus.err_clr = 0;
        tick();
        checking = 1;
        tick();
        chk("t1_out_data", 64'(bus.out_data), 64'd0);
        chk("t1_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t1_fill", 64'(bus.fill), 64'd0);
        chk("t1_taps", 64'(bus.taps_flat), 64'd0);
        chk("t1_tap_err", 64'(bus.tap_err), 64'd0);
        chk("t1_full", 64'(bus.full), 64'd0);

        // T2: chain fill
        idle();
        for (int n = 1; n <= 9; n++) begin
            bus.en = 1; bus.chain_valid = 1; bus.chain_data = W'(n);
            tick();
            chk("t2_fill", 64'(bus.fill), 64'((n < D) ? n : D));
            chk("t2_full", 64'(bus.full), 64'(n >= D));
            chk("t2_tap0", 64'(bus.taps_flat[0 +: W]), 64'(n));
            if (n >= 2) chk("t2_tap1", 64'(bus.taps_flat[W +: W]), 64'(n - 1));
            if (n >= 3) chk("t2_tap2", 64'(bus.taps_flat[2*W +: W]), 64'(n - 2));
        end

        // T3: tap 6 path, 9 en cycles
        do_reset();
        bus.src_sel = 1; bus.tap_sel = SW'(6);
        for (int i = 1; i <= 10; i++) begin
            bus.en = 1;
            bus.chain_valid = (i == 1);
            bus.chain_data  = (i == 1) ? 32'hA5A5_0001 : 32'h0;
            tick();
            chk("t3_out_valid", 64'(bus.out_valid), 64'(i == 9));
            if (i == 9) chk("t3_out_data", 64'(bus.out_data), 64'hA5A5_0001);
        end

        // T4: same with a 3-cycle stall mid-flight
        do_reset();
        bus.src_sel = 1; bus.tap_sel = SW'(6);
        for (int i = 1; i <= 13; i++) begin
            bus.en = !(i >= 5 && i <= 7);
            bus.chain_valid = (i == 1);
            bus.chain_data  = (i == 1) ? 32'hA5A5_0001 : 32'h0;
            tick();
            chk("t4_out_valid", 64'(bus.out_valid), 64'(i == 12));
            if (i == 12) chk("t4_out_data", 64'(bus.out_data), 64'hA5A5_0001);
        end

        // T5: flush and sticky tap error
        do_reset();
        bus.src_sel = 1; bus.tap_sel = '0;
        for (int i = 0; i < 5; i++) begin
            bus.en = 1; bus.chain_valid = 1; bus.chain_data = $urandom;
            tick();
        end
        chk("t5_fill5", 64'(bus.fill), 64'd5);
        chk("t5_ov_pre", 64'(bus.out_valid), 64'd1);
        bus.flush = 1;
        tick();
        chk("t5_fill_flushed", 64'(bus.fill), 64'd0);
        chk("t5_ov_flushed", 64'(bus.out_valid), 64'd0);
        bus.flush = 0; bus.chain_valid = 0; bus.tap_sel = SW'(7);
        tick();
        chk("t5_err_set", 64'(bus.tap_err), 64'd1);
        bus.src_sel = 0; bus.tap_sel = '0;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_err_hold", 64'(bus.tap_err), 64'd1);
        bus.err_clr = 1;
        tick();
        chk("t5_err_clr", 64'(bus.tap_err), 64'd0);
        bus.src_sel = 1; bus.tap_sel = SW'(7);
        tick();
        chk("t5_set_wins", 64'(bus.tap_err), 64'd1);

        // T6: external path, single-cycle word
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            bus.en = 1; bus.src_sel = 0;
            bus.ext_valid = (i == 1);
            bus.ext_data  = (i == 1) ? 32'hDEAD_BEEF : W'($urandom);
            tick();
            chk("t6_out_valid", 64'(bus.out_valid), 64'(i == 2));
            if (i == 2) chk("t6_out_data", 64'(bus.out_data), 64'hDEAD_BEEF);
        end

        // Random traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 99) < 1);
            bus.flush       = ($urandom_range(0, 99) < 3);
            bus.en          = ($urandom_range(0, 99) < 75);
            bus.err_clr     = ($urandom_range(0, 99) < 5);
            bus.chain_data  = $urandom;
            bus.chain_valid = 1'($urandom);
            bus.ext_data    = $urandom;
            bus.ext_valid   = 1'($urandom);
            bus.src_sel     = ($urandom_range(0, 99) < 70);
            bus.tap_sel     = SW'($urandom);
            tick();
        end

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
